// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix operand loader: FSM encoding and frame geometry.
package matrix_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    LOAD_B = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int A_ELEMS   = 16;
  localparam int B_ELEMS   = 9;
  localparam int FRAME_LEN = A_ELEMS + B_ELEMS;
  localparam int COUNT_W   = 5;

  localparam logic [COUNT_W-1:0] LAST_A_IDX = COUNT_W'(A_ELEMS - 1);
  localparam logic [COUNT_W-1:0] LAST_IDX   = COUNT_W'(FRAME_LEN - 1);

endpackage

// File: rtl/matrix_input_loader_if.sv
// Byte-stream valid/ready channel feeding the matrix loader; in_first marks element a11.
interface matrix_input_loader_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_first;
  logic              in_ready;

  modport master (output in_valid, in_data, in_first, input  in_ready);
  modport slave  (input  in_valid, in_data, in_first, output in_ready);
endinterface

// File: rtl/matrix_input_loader.sv
// Assembles a 25-beat stream into the 4x4 A and 3x3 B element buses, holds the frame
// until ack, and flags framing errors with a one-cycle err pulse.
module matrix_input_loader
  import matrix_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  matrix_input_loader_if.slave  stream,
  input  logic                  ack,
  output logic [DATA_W-1:0]     out_a11, out_a12, out_a13, out_a14,
  output logic [DATA_W-1:0]     out_a21, out_a22, out_a23, out_a24,
  output logic [DATA_W-1:0]     out_a31, out_a32, out_a33, out_a34,
  output logic [DATA_W-1:0]     out_a41, out_a42, out_a43, out_a44,
  output logic [DATA_W-1:0]     out_b11, out_b12, out_b13,
  output logic [DATA_W-1:0]     out_b21, out_b22, out_b23,
  output logic [DATA_W-1:0]     out_b31, out_b32, out_b33,
  output logic                  load_done,
  output logic [COUNT_W-1:0]    out_count,
  output logic                  err
);

  state_e               state_q, state_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 ready_q;
  logic                 err_q;
  logic [DATA_W-1:0]    elem_q [FRAME_LEN];

  logic                 xfer;
  logic                 wr_any;
  logic [COUNT_W-1:0]   wr_idx;
  logic [FRAME_LEN-1:0] wr_en;
  logic                 err_set;

  assign xfer            = stream.in_valid && ready_q;
  assign stream.in_ready = ready_q;

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; an in_first transfer always restarts the frame at LOAD_A.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (xfer && stream.in_first) state_d = LOAD_A;
      end
      LOAD_A: begin
        if (xfer) begin
          if (stream.in_first)             state_d = LOAD_A;
          else if (count_q == LAST_A_IDX)  state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        if (xfer) begin
          if (stream.in_first)             state_d = LOAD_A;
          else if (count_q == LAST_IDX)    state_d = DONE;
        end
      end
      DONE: begin
        if (ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath control: write index, count update, error detection.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_any    = 1'b0;
    wr_idx    = '0;
    err_set   = 1'b0;
    count_d   = count_q;
    load_done = (state_q == DONE);
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          if (stream.in_first) begin
            wr_any  = 1'b1;
            count_d = COUNT_W'(1);
          end else begin
            err_set = 1'b1;
          end
        end
      end
      LOAD_A, LOAD_B: begin
        if (xfer) begin
          wr_any = 1'b1;
          if (stream.in_first) begin
            err_set = 1'b1;
            count_d = COUNT_W'(1);
          end else begin
            wr_idx  = count_q;
            count_d = count_q + COUNT_W'(1);
          end
        end
      end
      DONE: begin
        if (ack) count_d = '0;
      end
      default: ;
    endcase
  end

  // One-hot element write enables decoded from the frame position.
  always_comb begin
    for (int i = 0; i < FRAME_LEN; i++) begin
      wr_en[i] = wr_any && (wr_idx == COUNT_W'(i));
    end
  end

  // NOTE: the element file is cleared on reset because the outputs must read
  // zero straight out of reset; it is small enough to live in flops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < FRAME_LEN; i++) elem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      ready_q <= (state_d != DONE);
      err_q   <= err_set;
      for (int i = 0; i < FRAME_LEN; i++) begin
        if (wr_en[i]) elem_q[i] <= stream.in_data;
      end
    end
  end

  assign out_count = count_q;
  assign err       = err_q;

  assign out_a11 = elem_q[0];
  assign out_a12 = elem_q[1];
  assign out_a13 = elem_q[2];
  assign out_a14 = elem_q[3];
  assign out_a21 = elem_q[4];
  assign out_a22 = elem_q[5];
  assign out_a23 = elem_q[6];
  assign out_a24 = elem_q[7];
  assign out_a31 = elem_q[8];
  assign out_a32 = elem_q[9];
  assign out_a33 = elem_q[10];
  assign out_a34 = elem_q[11];
  assign out_a41 = elem_q[12];
  assign out_a42 = elem_q[13];
  assign out_a43 = elem_q[14];
  assign out_a44 = elem_q[15];
  assign out_b11 = elem_q[16];
  assign out_b12 = elem_q[17];
  assign out_b13 = elem_q[18];
  assign out_b21 = elem_q[19];
  assign out_b22 = elem_q[20];
  assign out_b23 = elem_q[21];
  assign out_b31 = elem_q[22];
  assign out_b32 = elem_q[23];
  assign out_b33 = elem_q[24];

endmodule

// File: doc/matrix_input_loader.md
# matrix_input_loader

Front-end loader that receives the operand matrices as a byte stream over a valid/ready handshake and assembles them into the parallel 4x4 A and 3x3 B element buses consumed by `memory_module`. It is the producer end of the memory's a/b input interface and replaces direct bench or switch driving of those 25 ports. Once a complete frame is held stable, it raises `load_done` for the controller and waits for `ack` before accepting a new frame.

## Interface
- `DATA_W`, default 8: element width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `in_valid` in 1: source has a beat on `in_data`.
- `in_data` in DATA_W: element value.
- `in_first` in 1: qualifies the beat as element 0 (a11) of a frame.
- `in_ready` out 1: loader can accept a beat.
- `ack` in 1: consumer has latched the matrices; releases DONE.
- `out_a11` … `out_a44` out DATA_W each: A elements, row-major.
- `out_b11` … `out_b33` out DATA_W each: B elements, row-major.
- `load_done` out 1: a full frame is held.
- `out_count` out 5: beats accepted in the current frame, 0..25.
- `err` out 1: one-cycle framing-error pulse.

## Operation
- A transfer occurs at a rising edge where `in_valid && in_ready`.
- Frame order: index 0..15 maps to a11..a44 (row-major), index 16..24 maps to b11..b33.
- States:
  - IDLE: `in_ready`=1. A transfer with `in_first`=1 writes a11, sets count=1, and moves to LOAD_A. A transfer with `in_first`=0 is dropped, `err` pulses, and the state stays IDLE.
  - LOAD_A: each transfer writes A[count] and increments count. The transfer that writes index 15 moves to LOAD_B.
  - LOAD_B: each transfer writes B[count-16]. The transfer that writes index 24 moves to DONE.
  - DONE: `in_ready`=0, `load_done`=1, all element outputs frozen. `ack`=1 moves to IDLE and clears count to 0.
- Resync: a transfer with `in_first`=1 in LOAD_A or LOAD_B pulses `err`, writes a11, sets count=1, and moves to LOAD_A. Elements from the aborted frame keep their values until overwritten.
- `ack` outside DONE is ignored. `in_first` without a transfer is ignored.
- Element registers are written only on a transfer. Nothing is cleared except by reset.

## Timing
- Reset (`rst`=0 at an edge): state IDLE, all `out_*` elements 0, `out_count`=0, `load_done`=0, `err`=0, `in_ready`=0.
- `in_ready` is registered. It becomes 1 on the first edge with `rst`=1.
- An accepted element appears on its output port, and `out_count` updates, one cycle after the accepting edge.
- The loader sustains one transfer per cycle back-to-back, so a full frame takes a minimum of 25 cycles.
- On the edge accepting index 24, the next-cycle values are `in_ready`=0, `load_done`=1, `out_count`=25.
- On the `ack` edge in DONE, the next-cycle values are `load_done`=0, `in_ready`=1, `out_count`=0.
- `err` is high for exactly the one cycle following the offending edge.
- Reset asserted mid-frame aborts the frame. All outputs take their reset values on that edge.

## Structure
- Shared package `matrix_pkg`:
  - state encoding IDLE/LOAD_A/LOAD_B/DONE
  - `A_ELEMS`=16, `B_ELEMS`=9, `FRAME_LEN`=25, `COUNT_W`=5
- No sub-module. The FSM, count register and 25-entry element register file are implemented in one module. The element write-enable is decoded from count.

## Test plan
- Reset, then 25 back-to-back beats with values 1..25 and `in_first` on the first beat: a11=1, a44=16, b11=17, b33=25. `load_done`=1 and `in_ready`=0 one cycle after the 25th edge.
- Frame A={1,2,3,4; 2,3,4,5; 3,4,5,5; 3,4,5,5} and B={9,8,7; 8,7,6; 7,6,5}, with `in_valid` gaps every third cycle: outputs match exactly, and `out_count` advances only on transfers. Then `ack`: `load_done`=0, `in_ready`=1, `out_count`=0.
- While in DONE, drive `in_valid` with data 0xFF for 5 cycles: no output changes.
- 10 beats, then an `in_first` beat with 0xAA: `err` pulses for one cycle, a11=0xAA, `out_count`=1. Exactly 24 further beats are then required to reach DONE.
- In IDLE, a beat 0x55 without `in_first`: `err` pulses, `out_count`=0, a11 unchanged.
- `rst`=0 for one cycle at beat 20: all elements 0, `in_ready`=0, then 1 on the next cycle. A fresh 25-beat frame then completes normally.
